uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Receive-side UART frame sequencer. It owns the edge counter and the bit counter, and it drives the sample, deserializer, start/parity/stop check enables.
- It sits between the oversampling data sampler and the check blocks: parity checker, start checker, stop checker and deserializer.
- It decides frame acceptance and emits data_valid or frame_err per frame.
- Supports optional parity and back-to-back frames.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 6, width of prescale input and edge counter.
- BIT_CNT_WIDTH, 4, width of bit counter; must hold DATA_WIDTH.

Ports:
- CLK_PAR_CHECK  in  1  clock (oversampling clock); reset RST_PAR_CHECK, asynchronous, active-low; clock CLK_PAR_CHECK.
- RST_PAR_CHECK  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line, idle high.
- PAR_EN  in  1  parity bit present in frame.
- prescale  in  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32.
- strt_glitch  in  1  start checker result (registered), valid the cycle after strt_chk_en.
- par_err  in  1  parity checker result (registered), valid the cycle after par_chk_en.
- stp_err  in  1  stop checker result (registered), valid the cycle after stp_chk_en.
- dat_samp_en  out  1  sampler enable.
- deser_en  out  1  one-cycle shift strobe into deserializer.
- strt_chk_en  out  1  one-cycle start check strobe.
- par_chk_en  out  1  one-cycle parity check strobe.
- stp_chk_en  out  1  one-cycle stop check strobe.
- edge_cnt  out  PRESCALE_WIDTH  current oversample index within bit, 0..prescale-1.
- busy  out  1  frame in progress.
- data_valid  out  1  registered one-cycle pulse, frame accepted.
- frame_err  out  1  registered one-cycle pulse, frame rejected (parity or stop error).

Behaviour:
- Reset:
  - state=IDLE, edge_cnt=0, bit_cnt=0.
  - data_valid=0, frame_err=0, PAR_EN latch=0.
  - All enables 0, busy=0.
- States: IDLE, START, DATA, PARITY, STOP. State and counters are registered; enables and busy are decoded combinationally from them.
- Sample point S = prescale/2+2. Bit end E = prescale-1.
- edge_cnt:
  - Held 0 in IDLE.
  - Otherwise increments each cycle and wraps E→0.
  - Each wrap advances the bit position.
- IDLE:
  - RX_IN==0 → START next cycle, edge_cnt=0, PAR_EN latched.
  - PAR_EN changes mid-frame are ignored.
- START:
  - strt_chk_en=1 when edge_cnt==S.
  - At edge_cnt==E: strt_glitch=1 → IDLE (no strobes, no data_valid or frame_err); else → DATA with bit_cnt=0.
- DATA:
  - deser_en=1 when edge_cnt==S.
  - At E, bit_cnt increments.
  - When bit_cnt==DATA_WIDTH-1 at E, bit_cnt clears and the next state is PARITY if latched PAR_EN=1, else STOP.
- PARITY: par_chk_en=1 at edge_cnt==S; → STOP at E.
- STOP:
  - stp_chk_en=1 at edge_cnt==S.
  - At E, the accept condition is stp_err==0 AND (latched PAR_EN==0 OR par_err==0).
  - Accept → data_valid=1 next cycle; otherwise frame_err=1 next cycle. Exactly one of the two pulses per completed frame.
  - par_err is ignored when parity is disabled (a stale value must not reject the frame).
  - Next state at E: RX_IN==0 → START with edge_cnt=0 and PAR_EN relatched (back-to-back frame, no idle cycle); else IDLE.
- dat_samp_en = busy = (state != IDLE).
- Latency: start detected at cycle t0 → data_valid or frame_err at cycle t0 + (2+DATA_WIDTH+PAR)*prescale + 1.
- Reset mid-frame: immediate return to reset values; no pulse is emitted. After release, IDLE waits for RX_IN low.
- prescale changes while busy: undefined. Prescale values outside the legal set: undefined.

Test Plan:
- prescale=8, PAR_EN=1, byte 0xA5, good parity and stop:
  - 8 deser_en pulses at edge_cnt=6.
  - 1 strt_chk_en, 1 par_chk_en, 1 stp_chk_en.
  - data_valid high exactly at t0+89; frame_err stays 0; busy falls the same cycle.
- Same frame, checker returns par_err=1 → frame_err pulse at t0+89, no data_valid.
- RX_IN low for 2 cycles, strt_glitch=1 → return to IDLE at t0+8; zero deser_en pulses; no data_valid or frame_err.
- prescale=16, PAR_EN=0, par_err held 1, stp_err=0 → no par_chk_en; data_valid at t0+161.
- prescale=16, PAR_EN=0, par_err held 1, stp_err=1 → frame_err at t0+161.
- Two frames back-to-back (RX_IN=0 at stop E):
  - Second START begins the next cycle with no IDLE state.
  - Two data_valid pulses spaced 10*prescale cycles apart.
- Assert RST_PAR_CHECK during DATA bit 4 → all outputs 0 asynchronously; no pulse. After release, a new frame is received normally.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- receive-side UART frame sequencer.
//
// Walks each frame through START, DATA, optional PARITY and STOP. It keeps
// the oversample edge counter and the data bit counter, fires one-cycle
// strobes at the sample point of each bit for the sampler, deserializer and
// check blocks, and at the end of the stop bit decides whether the frame
// is accepted (data_valid) or rejected (frame_err).
//
// Ports:
//   CLK_PAR_CHECK  oversampling clock
//   RST_PAR_CHECK  asynchronous active-low reset
//   RX_IN          serial line, idle high
//   PAR_EN         parity bit present; latched at the start of each frame
//   prescale       oversampling ratio (8, 16 or 32)
//   strt_glitch    start checker result, valid the cycle after strt_chk_en
//   par_err        parity checker result, valid the cycle after par_chk_en
//   stp_err        stop checker result, valid the cycle after stp_chk_en
//   dat_samp_en    sampler enable (frame in progress)
//   deser_en       deserializer shift strobe at each data bit sample point
//   strt_chk_en    start check strobe
//   par_chk_en     parity check strobe
//   stp_chk_en     stop check strobe
//   edge_cnt       oversample index within the current bit
//   busy           frame in progress
//   data_valid     registered one-cycle pulse, frame accepted
//   frame_err      registered one-cycle pulse, frame rejected
module uart_rx_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      CLK_PAR_CHECK,
    input  logic                      RST_PAR_CHECK,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      strt_glitch,
    input  logic                      par_err,
    input  logic                      stp_err,
    output logic                      dat_samp_en,
    output logic                      deser_en,
    output logic                      strt_chk_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic                      busy,
    output logic                      data_valid,
    output logic                      frame_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                    state_r;
    state_t                    state_s;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_r;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_s;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt_r;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt_s;
    logic                      par_en_r;
    logic                      par_en_s;
    logic                      data_valid_r;
    logic                      data_valid_s;
    logic                      frame_err_r;
    logic                      frame_err_s;

    logic [PRESCALE_WIDTH-1:0] sample_pt_s;
    logic [PRESCALE_WIDTH-1:0] bit_end_s;
    logic                      at_sample_s;
    logic                      at_end_s;
    logic                      accept_s;

    // Sample point sits just past mid-bit so the sampler's majority window
    // has settled; bit end is the last oversample tick of the bit.
    assign sample_pt_s = (prescale >> 1) + PRESCALE_WIDTH'(2);
    assign bit_end_s   = prescale - PRESCALE_WIDTH'(1);
    assign at_sample_s = (edge_cnt_r == sample_pt_s);
    assign at_end_s    = (edge_cnt_r == bit_end_s);

    // A stale par_err must not reject a frame that carries no parity bit.
    assign accept_s = !stp_err && (!par_en_r || !par_err);

    // State register, counters, parity latch and result pulses.
    always_ff @(posedge CLK_PAR_CHECK or negedge RST_PAR_CHECK) begin
        if (!RST_PAR_CHECK) begin
            state_r      <= IDLE;
            edge_cnt_r   <= {PRESCALE_WIDTH{1'b0}};
            bit_cnt_r    <= {BIT_CNT_WIDTH{1'b0}};
            par_en_r     <= 1'b0;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            edge_cnt_r   <= edge_cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            par_en_r     <= par_en_s;
            data_valid_r <= data_valid_s;
            frame_err_r  <= frame_err_s;
        end
    end

    // Next-state, counter and frame-decision logic.
    always_comb begin
        state_s      = state_r;
        edge_cnt_s   = at_end_s ? {PRESCALE_WIDTH{1'b0}} : (edge_cnt_r + PRESCALE_WIDTH'(1));
        bit_cnt_s    = bit_cnt_r;
        par_en_s     = par_en_r;
        data_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        case (state_r)
            IDLE: begin
                edge_cnt_s = {PRESCALE_WIDTH{1'b0}};
                if (!RX_IN) begin
                    state_s   = START;
                    bit_cnt_s = {BIT_CNT_WIDTH{1'b0}};
                    par_en_s  = PAR_EN;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (at_end_s) begin
                    bit_cnt_s = {BIT_CNT_WIDTH{1'b0}};
                    state_s   = strt_glitch ? IDLE : DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (at_end_s) begin
                    if (bit_cnt_r == LAST_BIT) begin
                        bit_cnt_s = {BIT_CNT_WIDTH{1'b0}};
                        state_s   = par_en_r ? PARITY : STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_CNT_WIDTH'(1);
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (at_end_s) begin
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if (at_end_s) begin
                    data_valid_s = accept_s;
                    frame_err_s  = !accept_s;
                    // Line already low at stop end: next start bit, no idle gap.
                    if (!RX_IN) begin
                        state_s   = START;
                        bit_cnt_s = {BIT_CNT_WIDTH{1'b0}};
                        par_en_s  = PAR_EN;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s    = IDLE;
                edge_cnt_s = {PRESCALE_WIDTH{1'b0}};
                bit_cnt_s  = {BIT_CNT_WIDTH{1'b0}};
            end
        endcase
    end

    // Strobe and status decode from the registered state and edge counter.
    always_comb begin
        busy        = (state_r != IDLE);
        dat_samp_en = (state_r != IDLE);
        strt_chk_en = (state_r == START)  && at_sample_s;
        deser_en    = (state_r == DATA)   && at_sample_s;
        par_chk_en  = (state_r == PARITY) && at_sample_s;
        stp_chk_en  = (state_r == STOP)   && at_sample_s;
    end

    assign edge_cnt   = edge_cnt_r;
    assign data_valid = data_valid_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl. Stimulus pushes the expected frame
// result (kind, cycle, strobe counts, busy) when a frame is sent; a forked
// monitor pops and compares whenever data_valid or frame_err pulses.
module tb_uart_rx_ctrl;

    logic       clk;
    logic       rst_n;
    logic       rx_in;
    logic       par_en;
    logic [5:0] prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       dat_samp_en;
    logic       deser_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic [5:0] edge_cnt;
    logic       busy;
    logic       data_valid;
    logic       frame_err;

    uart_rx_ctrl #(
        .DATA_WIDTH    (8),
        .PRESCALE_WIDTH(6),
        .BIT_CNT_WIDTH (4)
    ) dut (
        .CLK_PAR_CHECK(clk),
        .RST_PAR_CHECK(rst_n),
        .RX_IN        (rx_in),
        .PAR_EN       (par_en),
        .prescale     (prescale),
        .strt_glitch  (strt_glitch),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .dat_samp_en  (dat_samp_en),
        .deser_en     (deser_en),
        .strt_chk_en  (strt_chk_en),
        .par_chk_en   (par_chk_en),
        .stp_chk_en   (stp_chk_en),
        .edge_cnt     (edge_cnt),
        .busy         (busy),
        .data_valid   (data_valid),
        .frame_err    (frame_err)
    );

    typedef struct {
        int kind;   // 1 = data_valid, 0 = frame_err
        int cyc;
        int n_deser;
        int n_par;
        int n_stp;
        int n_strt;
        int busy;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   cyc;
    int   ps;
    int   mon_deser;
    int   mon_par;
    int   mon_stp;
    int   mon_strt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: value visible after a posedge belongs to that cycle.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    // Counts strobes per frame and scores each result pulse.
    task automatic monitor();
        int   prev_busy;
        exp_t e;
        prev_busy = 0;
        forever begin
            @(negedge clk);
            if (busy && (prev_busy == 0)) begin
                mon_deser = 0; mon_par = 0; mon_stp = 0; mon_strt = 0;
            end
            prev_busy = int'(busy);
            if (deser_en) begin
                mon_deser = mon_deser + 1;
                check("deser_edge", int'(edge_cnt), ps / 2 + 2);
            end
            if (par_chk_en)  mon_par  = mon_par + 1;
            if (stp_chk_en)  mon_stp  = mon_stp + 1;
            if (strt_chk_en) mon_strt = mon_strt + 1;
            if (data_valid || frame_err) begin
                check("one_pulse", int'(data_valid && frame_err), 0);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("kind",    int'(data_valid), e.kind);
                    check("latency", cyc, e.cyc);
                    check("n_deser", mon_deser, e.n_deser);
                    check("n_par",   mon_par, e.n_par);
                    check("n_stp",   mon_stp, e.n_stp);
                    check("n_strt",  mon_strt, e.n_strt);
                    check("busy_at_pulse", int'(busy), e.busy);
                end
                mon_deser = 0; mon_par = 0; mon_stp = 0; mon_strt = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one full frame starting at the current negedge (t0 = cyc).
    // Returns at the negedge of the stop-bit end cycle, where the caller
    // may start a back-to-back frame or return the line to idle.
    task automatic send_frame(input int p, input bit pe, input logic [7:0] d,
                              input bit perr, input bit serr, input bit b2b);
        exp_t e;
        int   nbits;
        int   bi;
        ps          = p;
        prescale    = 6'(p);
        par_en      = pe;
        par_err     = perr;
        stp_err     = serr;
        strt_glitch = 1'b0;
        nbits       = pe ? 11 : 10;
        e.kind      = (!serr && (!pe || !perr)) ? 1 : 0;
        e.cyc       = cyc + nbits * p + 1;
        e.n_deser   = 8;
        e.n_par     = pe ? 1 : 0;
        e.n_stp     = 1;
        e.n_strt    = 1;
        e.busy      = b2b ? 1 : 0;
        sb.push_back(e);
        for (int k = 0; k < nbits * p; k++) begin
            bi = k / p;
            if (bi == 0)                 rx_in = 1'b0;
            else if (bi <= 8)            rx_in = d[bi-1];
            else if (pe && (bi == 9))    rx_in = even_par(d);
            else                         rx_in = 1'b1;
            // Mid-frame PAR_EN flips must not affect the frame.
            if (k == p + 1) par_en = ~pe;
            @(negedge clk);
        end
    endtask

    initial begin
        int t0;
        checks = 0; errors = 0; cyc = 0; ps = 8;
        mon_deser = 0; mon_par = 0; mon_stp = 0; mon_strt = 0;
        rst_n = 1'b0; rx_in = 1'b1; par_en = 1'b0; prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        fork
            monitor();
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
                    edge_cnt, busy, data_valid, frame_err}), 0);
        rst_n = 1'b1;
        idle(3);
        check("idle_busy", int'(busy), 0);
        check("idle_edge", int'(edge_cnt), 0);

        // prescale 8, parity on, 0xA5, good parity and stop.
        send_frame(8, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        idle(4);
        // Same frame, parity error.
        send_frame(8, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        idle(4);

        // Start glitch: line low two cycles, start checker reports glitch.
        ps = 8; prescale = 6'd8; strt_glitch = 1'b1;
        t0 = cyc;
        rx_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rx_in = 1'b1;
        while (cyc < t0 + 8) @(negedge clk);
        check("glitch_busy_at_end", int'(busy), 1);
        @(negedge clk);
        check("glitch_back_idle", int'(busy), 0);
        check("glitch_deser", mon_deser, 0);
        check("glitch_strt", mon_strt, 1);
        strt_glitch = 1'b0;
        idle(4);

        // prescale 16, parity off with stale par_err.
        send_frame(16, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0);
        idle(4);
        send_frame(16, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b0);
        idle(4);
        par_err = 1'b0;

        // Back-to-back frames, prescale 8, no parity.
        send_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        send_frame(8, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Reset during DATA bit 4: outputs clear at once, no pulse.
        ps = 8; prescale = 6'd8; par_en = 1'b1;
        rx_in = 1'b0;
        repeat (44) @(negedge clk);
        check("midframe_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              int'({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
                    edge_cnt, busy, data_valid, frame_err}), 0);
        rx_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        check("post_reset_idle", int'(busy), 0);

        // Normal frames after reset, including prescale 32.
        send_frame(8, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        idle(4);
        send_frame(32, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
